ctrl_seq: RTL and testbench

- Parametrised multicycle control sequencer for the CPU datapath.
- Decodes the opcode, steps the datapath through per-instruction states and evaluates the branch condition from ALU flags.
- Extends the previous sequencer with:
  - a separate branch-condition field,
  - memory wait handshaking for LD/SD,
  - a counted multicycle shift,
  - illegal-opcode detection.
- Sits between the instruction register and the datapath control decoder, which consumes the state code.

---
 rtl/ctrl_seq.sv | 162 ++++++++++++++++
 tb/tb_ctrl_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
// ctrl_seq: multicycle control sequencer that decodes the opcode and steps the datapath through per-instruction states.
// Define CTRL_SEQ_RETIRE_CNT_EN to add the 'retired' instruction counter output.
module ctrl_seq #(
    parameter int OP_W  = 4,
    parameter int SH_W  = 4,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   op,
    input  logic [2:0]        cond,
    input  logic [SH_W-1:0]   shamt,
    input  logic [2:0]        flag,
    input  logic              mem_ready,
    output logic [3:0]        state,
    output logic              mem_req,
    output logic              shift_busy,
    output logic              br_taken,
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
`else
    output logic              illegal
`endif
);

    typedef enum logic [3:0] {
        S_FETCH = 4'd0,
        S_NOR   = 4'd1,
        S_ADD   = 4'd2,
        S_LD    = 4'd3,
        S_SD    = 4'd4,
        S_SETI1 = 4'd5,
        S_SETI2 = 4'd6,
        S_SRL   = 4'd7,
        S_JL1   = 4'd8,
        S_JL2   = 4'd9,
        S_PC    = 4'd10,
        S_ILL   = 4'd11
    } state_e;

    if (OP_W < 3) begin : g_op_w_chk
        $error("ctrl_seq: OP_W must be >= 3");
    end
    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("ctrl_seq: CNT_W must be >= 1");
    end

    state_e          state_q, state_d;
    logic [SH_W-1:0] shift_cnt_q, shift_cnt_d;
    logic [2:0]      cond_q, cond_d;
    logic            br_taken_q, br_taken_d;
    logic            illegal_op;
    logic            br;

    function automatic logic br_eval(input logic [2:0] c, input logic [2:0] f);
        logic r;
        case (c)
            3'd0:    r = 1'b0;
            3'd1:    r = f[0];
            3'd2:    r = f[1];
            3'd3:    r = f[1] | f[0];
            3'd4:    r = f[2];
            3'd5:    r = f[2] | f[0];
            3'd6:    r = f[2] | f[1];
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // Any opcode bit above bit 2 set marks an opcode outside the defined 0..7 set.
    assign illegal_op = |(op >> 3);
    assign br         = br_eval(cond_q, flag);

    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        cond_d      = cond_q;
        br_taken_d  = br_taken_q;
        case (state_q)
            S_FETCH: begin
                cond_d = cond;
                if (illegal_op) begin
                    state_d = S_ILL;
                end else begin
                    case (op[2:0])
                        3'd0: state_d = S_NOR;
                        3'd1: state_d = S_ADD;
                        3'd2: state_d = S_LD;
                        3'd3: state_d = S_PC;
                        3'd4: state_d = S_SD;
                        3'd5: state_d = S_SETI1;
                        3'd6: state_d = S_JL1;
                        default: begin
                            state_d     = S_SRL;
                            shift_cnt_d = shamt;
                        end
                    endcase
                end
            end
            S_NOR, S_ADD, S_SETI2, S_ILL: state_d = S_PC;
            S_SETI1: state_d = S_SETI2;
            S_LD, S_SD: begin
                if (mem_ready) state_d = S_PC;
            end
            S_SRL: begin
                if (shift_cnt_q != '0) shift_cnt_d = shift_cnt_q - SH_W'(1);
                else                   state_d     = S_PC;
            end
            S_JL1: begin
                if (br) begin
                    state_d    = S_JL2;
                    br_taken_d = 1'b1;
                end else begin
                    state_d = S_PC;
                end
            end
            S_JL2, S_PC: state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
        // br_taken lives only for the duration of JL2.
        if (state_d == S_FETCH) br_taken_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            shift_cnt_q <= '0;
            cond_q      <= '0;
            br_taken_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            cond_q      <= cond_d;
            br_taken_q  <= br_taken_d;
        end
    end

`ifdef CTRL_SEQ_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;

    // PC and JL2 are the only states that hand control back to FETCH for a retired instruction.
    always_comb begin
        retired_d = retired_q;
        if (state_q == S_PC || state_q == S_JL2) retired_d = retired_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) retired_q <= '0;
        else     retired_q <= retired_d;
    end

    assign retired = retired_q;
`endif

    assign state      = state_q;
    assign mem_req    = (state_q == S_LD) || (state_q == S_SD);
    assign shift_busy = (state_q == S_SRL) && (shift_cnt_q != '0);
    assign br_taken   = br_taken_q;
    assign illegal    = (state_q == S_ILL);

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed testbench for ctrl_seq: hand-computed state sequences and output checks, sampled on the falling edge.
module tb_ctrl_seq;
    localparam int OP_W  = 4;
    localparam int SH_W  = 4;
    localparam int CNT_W = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [OP_W-1:0] op = 4'd1;
    logic [2:0]      cond = 3'd0;
    logic [SH_W-1:0] shamt = '0;
    logic [2:0]      flag = 3'd0;
    logic            mem_ready = 1'b0;
    logic [3:0]      state;
    logic            mem_req, shift_busy, br_taken, illegal;
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired;
`endif

    int n_vec = 0;
    int n_err = 0;

    ctrl_seq #(.OP_W(OP_W), .SH_W(SH_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .cond       (cond),
        .shamt      (shamt),
        .flag       (flag),
        .mem_ready  (mem_ready),
        .state      (state),
        .mem_req    (mem_req),
        .shift_busy (shift_busy),
        .br_taken   (br_taken),
`ifdef CTRL_SEQ_RETIRE_CNT_EN
        .illegal    (illegal),
        .retired    (retired)
`else
        .illegal    (illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic go_fetch;
        for (int i = 0; i < 40; i++) begin
            if (state == 4'd0) return;
            @(negedge clk);
        end
        chk("fetch_timeout", 32'(state), 32'd0);
    endtask

    // Runs one instruction from FETCH and checks the state codes that follow it.
    task automatic run_seq(input string tag, input logic [OP_W-1:0] o,
                           input int n, input logic [3:0] s0, input logic [3:0] s1,
                           input logic [3:0] s2, input logic [3:0] s3);
        logic [3:0] exp_s [4];
        exp_s[0] = s0; exp_s[1] = s1; exp_s[2] = s2; exp_s[3] = s3;
        go_fetch();
        op = o;
        for (int k = 0; k < n; k++) begin
            cyc();
            chk(tag, 32'(state), 32'(exp_s[k]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] add_seq [3];
        logic [7:0] mask;
        logic [2:0] fl;
        add_seq[0] = 4'd2; add_seq[1] = 4'd10; add_seq[2] = 4'd0;

        // Reset state with ADD opcode held
        cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_flags", 32'({mem_req, shift_busy, illegal, br_taken}), 32'd0);
        chk("rst_shcnt", 32'(dut.shift_cnt_q), 32'd0);
`ifdef CTRL_SEQ_RETIRE_CNT_EN
        chk("rst_retired", retired, 32'd0);
`endif
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("add_loop_state", 32'(state), 32'(add_seq[i % 3]));
            chk("add_loop_flags", 32'({mem_req, shift_busy, illegal, br_taken}), 32'd0);
        end

        // Single-step and multi-step instructions
        run_seq("nor_seq",  4'd0, 3, 4'd1, 4'd10, 4'd0, 4'd0);
        run_seq("nop_seq",  4'd3, 2, 4'd10, 4'd0, 4'd0, 4'd0);
        run_seq("seti_seq", 4'd5, 4, 4'd5, 4'd6, 4'd10, 4'd0);

        // LD with three wait cycles
        go_fetch();
        op = 4'd2; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("ld_state", 32'(state), 32'd3);
            chk("ld_mem_req", 32'(mem_req), 32'd1);
            op = 4'd3;
            if (i == 3) mem_ready = 1'b1;
        end
        cyc();
        chk("ld_exit_state", 32'(state), 32'd10);
        chk("ld_exit_req", 32'(mem_req), 32'd0);
        cyc();
        chk("ld_fetch", 32'(state), 32'd0);

        // SD with memory already ready: one cycle
        op = 4'd4;
        cyc();
        chk("sd_state", 32'(state), 32'd4);
        chk("sd_mem_req", 32'(mem_req), 32'd1);
        op = 4'd3;
        cyc();
        chk("sd_exit", 32'(state), 32'd10);
        mem_ready = 1'b0;

        // SRL shamt=5: six cycles, five busy; shamt change mid-shift ignored
        go_fetch();
        op = 4'd7; shamt = 4'd5;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("srl5_state", 32'(state), 32'd7);
            chk("srl5_busy", 32'(shift_busy), (i < 5) ? 32'd1 : 32'd0);
            shamt = 4'd15; op = 4'd3;
        end
        cyc();
        chk("srl5_exit", 32'(state), 32'd10);
        chk("srl5_exit_busy", 32'(shift_busy), 32'd0);

        // SRL shamt=0: one cycle, never busy
        go_fetch();
        op = 4'd7; shamt = 4'd0;
        cyc();
        chk("srl0_state", 32'(state), 32'd7);
        chk("srl0_busy", 32'(shift_busy), 32'd0);
        op = 4'd3;
        cyc();
        chk("srl0_exit", 32'(state), 32'd10);

        // Jump-and-link over all conditions for two flag patterns
        for (int p = 0; p < 2; p++) begin
            fl   = (p == 0) ? 3'b010 : 3'b101;
            mask = (p == 0) ? 8'b1100_1100 : 8'b1111_1010;
            for (int c = 0; c < 8; c++) begin
                go_fetch();
                op = 4'd6; cond = 3'(c); flag = fl;
                cyc();
                chk("jl1_state", 32'(state), 32'd8);
                chk("jl1_br", 32'(br_taken), 32'd0);
                cond = ~3'(c); op = 4'd3;
                cyc();
                if (mask[c]) begin
                    chk("jl_taken_state", 32'(state), 32'd9);
                    chk("jl_taken_br", 32'(br_taken), 32'd1);
                end else begin
                    chk("jl_nt_state", 32'(state), 32'd10);
                    chk("jl_nt_br", 32'(br_taken), 32'd0);
                end
                cyc();
                chk("jl_fetch_state", 32'(state), 32'd0);
                chk("jl_fetch_br", 32'(br_taken), 32'd0);
            end
        end

        // Illegal opcode 0xC after a fresh reset
        go_fetch();
        rst = 1'b1; #1; rst = 1'b0;
        op = 4'hC;
        cyc();
        chk("ill_state", 32'(state), 32'd11);
        chk("ill_pulse", 32'(illegal), 32'd1);
        op = 4'd3;
        cyc();
        chk("ill_exit", 32'(state), 32'd10);
        chk("ill_pulse_end", 32'(illegal), 32'd0);
        cyc();
        chk("ill_fetch", 32'(state), 32'd0);
`ifdef CTRL_SEQ_RETIRE_CNT_EN
        chk("ill_retired", retired, 32'd1);
`endif
        run_seq("ill8_seq", 4'h8, 2, 4'd11, 4'd10, 4'd0, 4'd0);

        // Async reset while LD is waiting
        go_fetch();
        op = 4'd2; mem_ready = 1'b0;
        cyc();
        cyc();
        chk("ldw_state", 32'(state), 32'd3);
        op = 4'd3;
        #2 rst = 1'b1;
        #1;
        chk("ldw_rst_state", 32'(state), 32'd0);
        chk("ldw_rst_req", 32'(mem_req), 32'd0);
        cyc();
        rst = 1'b0;

        // Async reset mid-shift with shamt=15
        go_fetch();
        op = 4'd7; shamt = 4'd15;
        cyc(); cyc(); cyc();
        chk("srlw_busy", 32'(shift_busy), 32'd1);
        op = 4'd3;
        #2 rst = 1'b1;
        #1;
        chk("srlw_rst_state", 32'(state), 32'd0);
        chk("srlw_rst_cnt", 32'(dut.shift_cnt_q), 32'd0);
        chk("srlw_rst_busy", 32'(shift_busy), 32'd0);
        cyc();
        rst = 1'b0;

        // Async reset in JL2 clears br_taken immediately
        go_fetch();
        op = 4'd6; cond = 3'd7;
        cyc();
        op = 4'd3;
        cyc();
        chk("jl2w_br", 32'(br_taken), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("jl2w_rst_br", 32'(br_taken), 32'd0);
        chk("jl2w_rst_state", 32'(state), 32'd0);
`ifdef CTRL_SEQ_RETIRE_CNT_EN
        chk("jl2w_rst_retired", retired, 32'd0);
`endif
        cyc();
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
